// File: rtl/freq_meter_pkg.sv
// ============================================================================
// Module   : freq_meter_pkg
// Brief    : Shared FSM state type and sizing helper for clk_freq_meter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_meter_pkg;

    localparam int c_state_w = 2;

    typedef enum logic [c_state_w-1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Width needed to hold 0..gate_cycles-1; never narrower than one bit.
    function automatic int gate_cnt_w(input int gate_cycles);
        return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module   : sync_edge_det
// Brief    : Multi-flop synchronizer for an asynchronous toggle plus a
//            history flop producing a one-cycle pulse on either transition.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

`default_nettype wire

// File: rtl/clk_freq_meter.sv
// ============================================================================
// Module   : clk_freq_meter
// Brief    : Counts transitions of a synchronized PLL-domain toggle over a
//            fixed gate window; reports count, range check and debounced OK.
//            Optional FREQ_METER_STICKY_ERR_EN adds err_clr / err_sticky.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int          GATE_CYCLES = 27000,
    parameter int          CNT_W       = 16,
    parameter int unsigned EXP_MIN     = 2100,
    parameter int unsigned EXP_MAX     = 2120,
    parameter int          OK_WINDOWS  = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             meas_tgl,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             in_range,
    output logic             overflow,
    output logic             freq_ok
`ifdef FREQ_METER_STICKY_ERR_EN
    ,
    input  logic             err_clr,
    output logic             err_sticky
`endif
);

    localparam int c_gate_w  = gate_cnt_w(GATE_CYCLES);
    localparam int c_prime_w = $clog2(SYNC_STAGES + 1);
    localparam int c_ok_w    = $clog2(OK_WINDOWS + 1);

    localparam logic [c_gate_w-1:0]  c_gate_last  = c_gate_w'(GATE_CYCLES - 1);
    localparam logic [c_prime_w-1:0] c_prime_last = c_prime_w'(SYNC_STAGES);
    localparam logic [c_ok_w-1:0]    c_ok_target  = c_ok_w'(OK_WINDOWS);
    localparam logic [CNT_W-1:0]     c_cnt_max    = '1;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_prime_w-1:0] r_prime_cnt;
    logic [c_gate_w-1:0]  r_gate_cnt;
    logic [CNT_W-1:0]     r_tcnt;
    logic                 r_win_ovf;
    logic [c_ok_w-1:0]    r_ok_run;

    logic [CNT_W-1:0]     r_meas_count;
    logic                 r_meas_valid;
    logic                 r_in_range;
    logic                 r_overflow;
    logic                 r_freq_ok;

    logic                 w_edge;
    logic                 w_abort;
    logic                 w_prime_done;
    logic                 w_run;
    logic                 w_win_end;
    logic                 w_edge_run;
    logic                 w_tcnt_full;
    logic [CNT_W-1:0]     w_tcnt_inc;
    logic                 w_ovf_final;
    logic [31:0]          w_count32;
    logic                 w_in_range;
    logic [c_ok_w-1:0]    w_ok_run_inc;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk     (clk),
        .rst     (rst),
        .i_async (meas_tgl),
        .o_edge  (w_edge)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        w_prime_done = 1'b0;
        w_run        = 1'b0;
        w_win_end    = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_next = PRIME;
                end
            end
            PRIME: begin
                if (!en) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end else if (r_prime_cnt == c_prime_last) begin
                    w_state_next = RUN;
                    w_prime_done = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_run     = 1'b1;
                    w_win_end = (r_gate_cnt == c_gate_last);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    // The boundary cycle's own edge is folded into the final window value.
    assign w_edge_run   = w_run & w_edge;
    assign w_tcnt_full  = (r_tcnt == c_cnt_max);
    assign w_tcnt_inc   = (w_edge_run && !w_tcnt_full) ? r_tcnt + CNT_W'(1) : r_tcnt;
    assign w_ovf_final  = r_win_ovf | (w_edge_run & w_tcnt_full);
    assign w_count32    = 32'(w_tcnt_inc);
    assign w_in_range   = !w_ovf_final && (w_count32 >= EXP_MIN) && (w_count32 <= EXP_MAX);
    assign w_ok_run_inc = (r_ok_run == c_ok_target) ? r_ok_run : r_ok_run + c_ok_w'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prime_cnt  <= '0;
            r_gate_cnt   <= '0;
            r_tcnt       <= '0;
            r_win_ovf    <= 1'b0;
            r_ok_run     <= '0;
            r_meas_count <= '0;
            r_meas_valid <= 1'b0;
            r_in_range   <= 1'b0;
            r_overflow   <= 1'b0;
            r_freq_ok    <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (w_abort) begin
                r_prime_cnt <= '0;
                r_gate_cnt  <= '0;
                r_tcnt      <= '0;
                r_win_ovf   <= 1'b0;
                r_ok_run    <= '0;
                r_freq_ok   <= 1'b0;
            end else begin
                if (r_state == PRIME && !w_prime_done) begin
                    r_prime_cnt <= r_prime_cnt + c_prime_w'(1);
                end else begin
                    r_prime_cnt <= '0;
                end

                if (w_win_end) begin
                    // Next window starts immediately, so no transition is lost.
                    r_gate_cnt   <= '0;
                    r_tcnt       <= '0;
                    r_win_ovf    <= 1'b0;
                    r_meas_count <= w_tcnt_inc;
                    r_meas_valid <= 1'b1;
                    r_in_range   <= w_in_range;
                    r_overflow   <= w_ovf_final;
                    if (w_in_range) begin
                        r_ok_run  <= w_ok_run_inc;
                        r_freq_ok <= (w_ok_run_inc == c_ok_target);
                    end else begin
                        r_ok_run  <= '0;
                        r_freq_ok <= 1'b0;
                    end
                end else if (w_run) begin
                    r_gate_cnt <= r_gate_cnt + c_gate_w'(1);
                    r_tcnt     <= w_tcnt_inc;
                    r_win_ovf  <= w_ovf_final;
                end
            end
        end
    end

`ifdef FREQ_METER_STICKY_ERR_EN
    logic r_err_sticky;
    logic w_win_bad;

    assign w_win_bad = w_win_end & !w_in_range;

    // A bad window in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_win_bad) begin
            r_err_sticky <= 1'b1;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
        end
    end

    assign err_sticky = r_err_sticky;
`endif

    assign meas_count = r_meas_count;
    assign meas_valid = r_meas_valid;
    assign in_range   = r_in_range;
    assign overflow   = r_overflow;
    assign freq_ok    = r_freq_ok;

endmodule

`default_nettype wire

// File: tb/tb_clk_freq_meter.sv
// ============================================================================
// Module   : tb_clk_freq_meter
// Brief    : Scoreboard bench for clk_freq_meter using small-window and
//            saturating-counter instances with directed toggle patterns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, tgl_a, en_b, tgl_b, err_clr;
    logic [15:0] cnt_a;
    logic        valid_a, inr_a, ovf_a, fok_a;
    logic [3:0]  cnt_b;
    logic        valid_b, inr_b, ovf_b, fok_b;
`ifdef FREQ_METER_STICKY_ERR_EN
    logic        err_a, err_b;
`endif

    typedef struct {
        int cyc;
        int cnt;
        bit inr;
        bit ovf;
        bit fok;
        bit err;
        bit run1;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks   = 0;
    int errors   = 0;
    int edge_no  = 0;
    int sum_run1 = 0;
    int tally    = 0;
    int base_a   = 0;
    int base_b   = 0;
    bit ev_a, ev_b;

    // Run-1 window table: w4 is the fast (bad) window, w9 carries the
    // extra toggle placed on the gate_cnt==99 cycle.
    int r1_cnt [11] = '{25, 25, 25, 25, 50, 25, 25, 25, 25, 26, 25};
    bit r1_fok [11] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1};
    bit r1_err [11] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    clk_freq_meter #(
        .GATE_CYCLES (100), .CNT_W (16), .EXP_MIN (24), .EXP_MAX (26),
        .OK_WINDOWS (4), .SYNC_STAGES (2)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en_a),
        .meas_tgl   (tgl_a),
        .meas_count (cnt_a),
        .meas_valid (valid_a),
        .in_range   (inr_a),
        .overflow   (ovf_a),
        .freq_ok    (fok_a)
`ifdef FREQ_METER_STICKY_ERR_EN
        ,
        .err_clr    (err_clr),
        .err_sticky (err_a)
`endif
    );

    clk_freq_meter #(
        .GATE_CYCLES (100), .CNT_W (4), .EXP_MIN (24), .EXP_MAX (26),
        .OK_WINDOWS (4), .SYNC_STAGES (2)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en_b),
        .meas_tgl   (tgl_b),
        .meas_count (cnt_b),
        .meas_valid (valid_b),
        .in_range   (inr_b),
        .overflow   (ovf_b),
        .freq_ok    (fok_b)
`ifdef FREQ_METER_STICKY_ERR_EN
        ,
        .err_clr    (1'b0),
        .err_sticky (err_b)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int cyc, input int cnt, input bit inr, input bit ovf,
                          input bit fok, input bit err, input bit run1);
        exp_t e;
        e.cyc = cyc; e.cnt = cnt; e.inr = inr; e.ovf = ovf;
        e.fok = fok; e.err = err; e.run1 = run1;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int cyc, input int cnt, input bit inr, input bit ovf);
        exp_t e;
        e.cyc = cyc; e.cnt = cnt; e.inr = inr; e.ovf = ovf;
        e.fok = 1'b0; e.err = 1'b0; e.run1 = 1'b0;
        q_b.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever a DUT reports a window.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_a) begin : mon_a
                exp_t e;
                if (q_a.size() == 0) begin
                    chk("a_unexpected_valid", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    chk("a_valid_cycle", edge_no, e.cyc);
                    chk("a_count", int'(cnt_a), e.cnt);
                    chk("a_in_range", int'(inr_a), int'(e.inr));
                    chk("a_overflow", int'(ovf_a), int'(e.ovf));
                    chk("a_freq_ok", int'(fok_a), int'(e.fok));
`ifdef FREQ_METER_STICKY_ERR_EN
                    chk("a_err_sticky", int'(err_a), int'(e.err));
`endif
                    if (e.run1) sum_run1 += int'(cnt_a);
                end
            end
            if (valid_b) begin : mon_b
                exp_t e;
                if (q_b.size() == 0) begin
                    chk("b_unexpected_valid", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    chk("b_valid_cycle", edge_no, e.cyc);
                    chk("b_count", int'(cnt_b), e.cnt);
                    chk("b_in_range", int'(inr_b), int'(e.inr));
                    chk("b_overflow", int'(ovf_b), int'(e.ovf));
                    chk("b_freq_ok", int'(fok_b), int'(e.fok));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    // Saturating-counter instance: 50 toggles into a 4-bit counter, then 13.
    initial begin
        en_b  = 1'b0;
        tgl_b = 1'b0;
        repeat (10) step();
        base_b = edge_no;
        push_b(base_b + 104, 15, 1'b0, 1'b1);
        push_b(base_b + 204, 13, 1'b0, 1'b0);
        en_b = 1'b1;
        for (int k = 0; k < 230; k++) begin
            ev_b = (k <= 101) ? (k % 2 == 0) : (k % 8 == 0);
            if (ev_b) tgl_b = ~tgl_b;
            step();
        end
        en_b = 1'b0;
    end

    initial begin
        rst     = 1'b1;
        en_a    = 1'b0;
        tgl_a   = 1'b0;
        err_clr = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_a_count", int'(cnt_a), 0);
        chk("rst_a_valid", int'(valid_a), 0);
        chk("rst_a_in_range", int'(inr_a), 0);
        chk("rst_a_overflow", int'(ovf_a), 0);
        chk("rst_a_freq_ok", int'(fok_a), 0);
        chk("rst_b_count", int'(cnt_b), 0);
        chk("rst_b_overflow", int'(ovf_b), 0);
`ifdef FREQ_METER_STICKY_ERR_EN
        chk("rst_a_err_sticky", int'(err_a), 0);
`endif
        rst = 1'b0;
        step();

        // Run 1: steady period-4, one period-2 window, boundary toggle, abort.
        base_a = edge_no;
        for (int w = 0; w < 11; w++) begin
            push_a(base_a + 104 + 100 * w, r1_cnt[w], r1_cnt[w] != 50, 1'b0,
                   r1_fok[w], r1_err[w], 1'b1);
        end
        en_a = 1'b1;
        for (int k = 0; k < 1220; k++) begin
            if (k >= 402 && k <= 501) ev_a = (k % 2 == 0);
            else                      ev_a = (k % 4 == 0) || (k == 1001);
            if (ev_a) begin
                tgl_a = ~tgl_a;
                if (k >= 2 && k <= 1101) tally++;
            end
            err_clr = (k == 750);
            if (k == 1154) en_a = 1'b0;
            step();
        end
        @(negedge clk);
        chk("run1_sum_vs_driven", sum_run1, tally);
        chk("abort_count_held", int'(cnt_a), 25);
        chk("abort_in_range_held", int'(inr_a), 1);
        chk("abort_overflow_held", int'(ovf_a), 0);
        chk("abort_freq_ok", int'(fok_a), 0);
        chk("run1_pending", q_a.size(), 0);
        step();

        // Run 2: re-enable, one good then one bad window with coinciding clear.
        base_a = edge_no;
        push_a(base_a + 104, 25, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_a(base_a + 204, 50, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        en_a = 1'b1;
        for (int k = 0; k < 250; k++) begin
            ev_a = (k >= 102 && k <= 201) ? (k % 2 == 0) : (k % 4 == 0);
            if (ev_a) tgl_a = ~tgl_a;
            err_clr = (k == 203);
            step();
        end

        // Mid-window reset overrides en.
        rst     = 1'b1;
        en_a    = 1'b0;
        err_clr = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_count", int'(cnt_a), 0);
        chk("midrst_in_range", int'(inr_a), 0);
        chk("midrst_overflow", int'(ovf_a), 0);
        chk("midrst_freq_ok", int'(fok_a), 0);
        chk("midrst_valid", int'(valid_a), 0);
`ifdef FREQ_METER_STICKY_ERR_EN
        chk("midrst_err_sticky", int'(err_a), 0);
`endif
        repeat (150) step();
        chk("a_pending_at_end", q_a.size(), 0);
        chk("b_pending_at_end", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
